uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
UART receive front end that sits directly upstream of the SIPO_REG deserializer. It synchronizes the raw serial line, detects and qualifies the start bit, and samples each data bit at mid-bit using a clock-count bit timer. For every data bit it drives the sampled value plus a one-cycle shift enable to the downstream SIPO. It also keeps its own LSB-first copy of the byte and reports frame completion or a framing error.

Parameters:
DATA_WIDTH, 8, data bits per frame; must match the downstream SIPO DATA_WIDTH.
CLKS_PER_BIT, 16, clk cycles per bit period; even, at least 4.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
rx  input  1  raw serial line; idle high; asynchronous to clk.
serial_out  output  1  sampled data bit; feeds SIPO serial_in.
shift_en  output  1  one-cycle strobe per data bit; feeds SIPO shift_en.
data_out  output  DATA_WIDTH  last good frame, LSB-first assembled.
rx_valid  output  1  one-cycle pulse: good frame, data_out updated.
frame_err  output  1  one-cycle pulse: stop bit sampled low.
busy  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset (reset = 0, async): state IDLE; counters 0; both sync flops 1; all outputs 0, data_out = 0. The block recovers cleanly from reset asserted mid-frame.
- Input sync: 2-flop synchronizer on rx gives rx_s, with 2 cycles of latency. All decisions use rx_s only.
- Bit timer: cnt has width $clog2(CLKS_PER_BIT). It clears on every state entry and increments once per clk.
- IDLE: busy = 0. When rx_s = 0, go to START.
- START: at cnt = CLKS_PER_BIT/2 - 1, sample rx_s.
  - rx_s = 0: go to DATA, bit_idx = 0.
  - rx_s = 1: glitch; go to IDLE with no output activity.
- DATA: at cnt = CLKS_PER_BIT - 1, sample rx_s. On the following cycle:
  - serial_out = sample.
  - shift_en = 1 for exactly one cycle.
  - Internal shift register shifts right, with the new bit entering the MSB.
  - bit_idx increments.
  - After bit DATA_WIDTH-1, go to STOP.
- STOP: at cnt = CLKS_PER_BIT - 1, sample rx_s.
  - rx_s = 1: next cycle data_out = shift register and rx_valid = 1 for one cycle; go to IDLE.
  - rx_s = 0: next cycle frame_err = 1 for one cycle; data_out holds its previous value; go to BREAK.
- BREAK: stay until rx_s = 1, then go to IDLE. A line held low never re-triggers a start.
- Between shift_en pulses, serial_out holds its last value. shift_en is never asserted in START, STOP or BREAK.
- Per frame: exactly DATA_WIDTH shift_en pulses, spaced CLKS_PER_BIT cycles apart.
- rx_valid and frame_err are mutually exclusive.
- Back-to-back frames: a new start bit arriving directly after a stop bit is accepted. The re-entry through IDLE costs 1 cycle, which is within tolerance.
- Timing from the rx_s falling edge: first data-bit sample at CLKS_PER_BIT/2 + CLKS_PER_BIT cycles; rx_valid roughly (DATA_WIDTH+1.5)*CLKS_PER_BIT cycles later.

Test Plan:
- Frame 0xA5 (CLKS_PER_BIT = 16, stop = 1):
  - serial_out at the shift_en pulses = 1,0,1,0,0,1,0,1.
  - 8 shift_en pulses, 16 cycles apart.
  - Single rx_valid with data_out = 8'hA5; frame_err never high; busy low afterwards.
- rx low for 4 cycles in idle -> START rejects the start bit; no shift_en, rx_valid or busy beyond the START window; data_out unchanged.
- Frame 0x3C with stop bit 0, then rx held low 100 cycles, then high:
  - frame_err pulses once; no rx_valid; data_out keeps its prior value.
  - No new frame starts until rx returns high.
  - Then a 0x5A frame yields rx_valid with data_out = 8'h5A.
- Back-to-back frames 0x00, 0xFF, 0x81 with no idle gap -> three rx_valid pulses with data_out = 00, FF, 81 in order; 24 shift_en pulses total.
- reset pulsed low during data bit 3 of a frame:
  - All outputs go to 0 immediately.
  - The remainder of the frame does not produce rx_valid; it may produce a frame_err or be ignored.
  - The next clean 0x96 frame is received correctly.
- Integration with SIPO_REG (DATA_WIDTH = 8) on frame 0xC3 -> the SIPO output matches the SIPO's shift order for the bit sequence 1,1,0,0,0,0,1,1.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive front end feeding a SIPO deserializer.
// Synchronizes rx, qualifies the start bit, samples data bits mid-bit,
// strobes each bit downstream and reports frame completion or framing error.

module uart_rx_ctrl #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx,
   output logic                  serial_out,
   output logic                  shift_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  rx_valid,
   output logic                  frame_err,
   output logic                  busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  sync1_q, sync1_d;
   logic                  sync2_q, sync2_d;
   logic                  serial_out_q, serial_out_d;
   logic                  shift_en_q, shift_en_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  frame_err_q, frame_err_d;
   logic                  rx_s;

   assign rx_s = sync2_q;

   // Next-state and output logic; the bit timer restarts on every state entry
   // and after each data bit so every sample point is measured from a known edge.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q + 1'b1;
      bit_idx_d    = bit_idx_q;
      shreg_d      = shreg_q;
      data_out_d   = data_out_q;
      serial_out_d = serial_out_q;
      shift_en_d   = 1'b0;
      rx_valid_d   = 1'b0;
      frame_err_d  = 1'b0;
      sync1_d      = rx;
      sync2_d      = sync1_q;

      case (state_q)
         ST_IDLE: begin
            if (!rx_s) begin
               state_d = ST_START;
               cnt_d   = '0;
            end
         end

         ST_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d   = ST_DATA;
                  bit_idx_d = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         ST_DATA: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d        = '0;
               serial_out_d = rx_s;
               shift_en_d   = 1'b1;
               shreg_d      = {rx_s, shreg_q[DATA_WIDTH-1:1]};
               bit_idx_d    = bit_idx_q + 1'b1;
               if (bit_idx_q == IDX_LAST) begin
                  state_d = ST_STOP;
               end
            end
         end

         ST_STOP: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d = '0;
               if (rx_s) begin
                  data_out_d = shreg_q;
                  rx_valid_d = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = ST_BREAK;
               end
            end
         end

         ST_BREAK: begin
            if (rx_s) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State, timer, synchronizer and output registers; the synchronizer resets
   // to the idle-high line level so reset never looks like a start bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         shreg_q      <= '0;
         data_out_q   <= '0;
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         serial_out_q <= 1'b0;
         shift_en_q   <= 1'b0;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_idx_q    <= bit_idx_d;
         shreg_q      <= shreg_d;
         data_out_q   <= data_out_d;
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         serial_out_q <= serial_out_d;
         shift_en_q   <= shift_en_d;
         rx_valid_q   <= rx_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign serial_out = serial_out_q;
   assign shift_en   = shift_en_q;
   assign data_out   = data_out_q;
   assign rx_valid   = rx_valid_q;
   assign frame_err  = frame_err_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed bench for uart_rx_ctrl with a small SIPO model
// on the shift_en/serial_out pair.

module tb_uart_rx_ctrl;

   localparam int DW   = 8;
   localparam int CLKS = 16;

   logic          clk;
   logic          reset;
   logic          rx;
   logic          serial_out;
   logic          shift_en;
   logic [DW-1:0] data_out;
   logic          rx_valid;
   logic          frame_err;
   logic          busy;

   int checkCount = 0;
   int passCount  = 0;
   int cycleCount = 0;
   int frameStart = 0;

   logic          bitQ[$];
   int            shiftTimes[$];
   logic [DW-1:0] validQ[$];
   int            validTimes[$];
   int            shiftCount;
   int            errCount;
   int            busyCycles;
   int            mutexCount;
   logic [DW-1:0] sipo;

   uart_rx_ctrl #(
      .DATA_WIDTH  (DW),
      .CLKS_PER_BIT(CLKS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .serial_out(serial_out),
      .shift_en  (shift_en),
      .data_out  (data_out),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   // Free-running clock and cycle counter used for timing measurements
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycleCount++;

   // Observe outputs away from the active edge and model the downstream SIPO
   always @(negedge clk) begin
      if (shift_en) begin
         bitQ.push_back(serial_out);
         shiftTimes.push_back(cycleCount);
         sipo = {serial_out, sipo[DW-1:1]};
         shiftCount++;
      end
      if (rx_valid) begin
         validQ.push_back(data_out);
         validTimes.push_back(cycleCount);
      end
      if (frame_err) errCount++;
      if (rx_valid && frame_err) mutexCount++;
      if (busy) busyCycles++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic clearMonitor();
      bitQ.delete();
      shiftTimes.delete();
      validQ.delete();
      validTimes.delete();
      shiftCount = 0;
      errCount   = 0;
      busyCycles = 0;
      mutexCount = 0;
      sipo       = '0;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one frame starting at the current negedge: start, LSB-first data, stop
   task automatic applyStimulus(input logic [DW-1:0] data, input logic stopBit);
      rx = 1'b0;
      frameStart = cycleCount;
      waitCycles(CLKS);
      for (int i = 0; i < DW; i++) begin
         rx = data[i];
         waitCycles(CLKS);
      end
      rx = stopBit;
      waitCycles(CLKS);
   endtask

   function automatic logic [31:0] seqBits();
      logic [DW-1:0] v;
      v = '0;
      for (int i = 0; i < DW; i++) begin
         if (i < bitQ.size()) v[DW-1-i] = bitQ[i];
      end
      return {24'h0, v};
   endfunction

   function automatic logic [31:0] getValid(input int idx);
      if (idx < validQ.size()) return {24'h0, validQ[idx]};
      return 32'hDEAD;
   endfunction

   function automatic int badSpacing();
      int bad;
      bad = 0;
      for (int i = 1; i < shiftTimes.size(); i++) begin
         if (shiftTimes[i] - shiftTimes[i-1] != CLKS) bad++;
      end
      return bad;
   endfunction

   initial begin
      rx    = 1'b1;
      reset = 1'b0;
      clearMonitor();
      waitCycles(4);

      // Reset state
      checkOutput("rst serial_out", serial_out, 0);
      checkOutput("rst shift_en", shift_en, 0);
      checkOutput("rst data_out", data_out, 0);
      checkOutput("rst rx_valid", rx_valid, 0);
      checkOutput("rst frame_err", frame_err, 0);
      checkOutput("rst busy", busy, 0);
      reset = 1'b1;
      waitCycles(5);

      // Frame 0xA5 with good stop bit
      clearMonitor();
      applyStimulus(8'hA5, 1'b1);
      waitCycles(20);
      checkOutput("A5 shift count", shiftCount, 8);
      checkOutput("A5 serial seq", seqBits(), 32'b1010_0101);
      checkOutput("A5 shift spacing", badSpacing(), 0);
      checkOutput("A5 first sample time",
                  (shiftTimes.size() > 0) ? shiftTimes[0] - frameStart : -1, 27);
      checkOutput("A5 valid count", validQ.size(), 1);
      checkOutput("A5 data_out", getValid(0), 32'hA5);
      checkOutput("A5 valid time",
                  (validTimes.size() > 0) ? validTimes[0] - frameStart : -1, 155);
      checkOutput("A5 frame_err", errCount, 0);
      checkOutput("A5 busy after", busy, 0);
      checkOutput("A5 sipo", sipo, 32'hA5);

      // Short glitch rejected in START
      clearMonitor();
      rx = 1'b0;
      waitCycles(4);
      rx = 1'b1;
      waitCycles(30);
      checkOutput("glitch shifts", shiftCount, 0);
      checkOutput("glitch valid", validQ.size(), 0);
      checkOutput("glitch busy cycles", busyCycles, 8);
      checkOutput("glitch busy after", busy, 0);
      checkOutput("glitch data_out", data_out, 32'hA5);

      // Framing error then break, then recovery with 0x5A
      clearMonitor();
      applyStimulus(8'h3C, 1'b0);
      checkOutput("3C serial seq", seqBits(), 32'b0011_1100);
      waitCycles(100);
      checkOutput("3C frame_err count", errCount, 1);
      checkOutput("3C no valid", validQ.size(), 0);
      checkOutput("3C data_out held", data_out, 32'hA5);
      checkOutput("break no restart", shiftCount, 8);
      checkOutput("break busy", busy, 1);
      rx = 1'b1;
      waitCycles(10);
      checkOutput("break exit busy", busy, 0);
      clearMonitor();
      applyStimulus(8'h5A, 1'b1);
      waitCycles(20);
      checkOutput("5A valid count", validQ.size(), 1);
      checkOutput("5A data_out", getValid(0), 32'h5A);
      checkOutput("5A frame_err", errCount, 0);

      // Back-to-back frames without idle gap
      clearMonitor();
      applyStimulus(8'h00, 1'b1);
      applyStimulus(8'hFF, 1'b1);
      applyStimulus(8'h81, 1'b1);
      waitCycles(20);
      checkOutput("b2b valid count", validQ.size(), 3);
      checkOutput("b2b data 0", getValid(0), 32'h00);
      checkOutput("b2b data 1", getValid(1), 32'hFF);
      checkOutput("b2b data 2", getValid(2), 32'h81);
      checkOutput("b2b shift count", shiftCount, 24);
      checkOutput("b2b frame_err", errCount, 0);
      checkOutput("b2b exclusive", mutexCount, 0);

      // Asynchronous reset during data bit 3 of frame 0xFC
      clearMonitor();
      fork
         applyStimulus(8'hFC, 1'b1);
         begin
            waitCycles(70);
            checkOutput("mid busy", busy, 1);
            checkOutput("mid shifts", shiftCount, 3);
            checkOutput("mid serial_out", serial_out, 1);
            checkOutput("mid data_out", data_out, 32'h81);
            reset = 1'b0;
            #1;
            checkOutput("async rst busy", busy, 0);
            checkOutput("async rst data_out", data_out, 0);
            checkOutput("async rst serial_out", serial_out, 0);
            checkOutput("async rst shift_en", shift_en, 0);
            waitCycles(3);
            reset = 1'b1;
         end
      join
      waitCycles(30);
      checkOutput("abort no valid", validQ.size(), 0);
      clearMonitor();
      applyStimulus(8'h96, 1'b1);
      waitCycles(20);
      checkOutput("96 valid count", validQ.size(), 1);
      checkOutput("96 data_out", getValid(0), 32'h96);

      // SIPO integration on frame 0xC3
      clearMonitor();
      applyStimulus(8'hC3, 1'b1);
      waitCycles(20);
      checkOutput("C3 serial seq", seqBits(), 32'b1100_0011);
      checkOutput("C3 sipo", sipo, 32'hC3);
      checkOutput("C3 data_out", getValid(0), 32'hC3);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
